// File: rtl/sf_match_pkg.sv
// Shared phase encodings, winner codes and small helpers for the match sequencer.
package sf_match_pkg;

    localparam int unsigned BCD_W = 4;

    typedef enum logic [2:0] {
        PH_IDLE       = 3'd0,
        PH_COUNTDOWN  = 3'd1,
        PH_FIGHT      = 3'd2,
        PH_ROUND_END  = 3'd3,
        PH_MATCH_OVER = 3'd4
    } phase_e;

    // Winner codes deliberately match the game core's finish encoding.
    typedef logic [1:0] winner_t;
    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b11;
    localparam winner_t WIN_DRAW = 2'b10;

    function automatic logic [1:0] tally_inc(input logic [1:0] t);
        return (t == 2'd3) ? t : t + 2'd1;
    endfunction

    function automatic winner_t compare_winner(input logic [3:0] a, input logic [3:0] b);
        if (a > b) begin
            return WIN_P1;
        end
        if (b > a) begin
            return WIN_P2;
        end
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: single-cycle tick every SEC_CYCLES clocks, restartable by clear.
module sec_tick_gen #(
    parameter int unsigned SEC_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SEC_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: countdown, BCD round timer, round resolution and best-of-N tally
// for the street-fighter core, with all overlay outputs registered.
module match_controller #(
    parameter int unsigned SEC_CYCLES    = 100_000_000,
    parameter int unsigned ROUND_SECONDS = 99,
    parameter int unsigned END_SECONDS   = 3,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned MAX_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [1:0] finish,
    input  logic [3:0] p1_health,
    input  logic [3:0] p2_health,
    output logic       game_rst_n,
    output logic       freeze,
    output logic [2:0] phase,
    output logic [1:0] countdown,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic [2:0] round_num,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] round_winner,
    output logic       match_over,
    output logic [1:0] match_winner
);

    import sf_match_pkg::*;

    localparam int unsigned END_W = (END_SECONDS > 1) ? $clog2(END_SECONDS) : 1;
    localparam logic [END_W-1:0] END_LAST = END_W'(END_SECONDS - 1);
    localparam logic [BCD_W-1:0] RS_TENS  = BCD_W'(ROUND_SECONDS / 10);
    localparam logic [BCD_W-1:0] RS_ONES  = BCD_W'(ROUND_SECONDS % 10);

    phase_e           state_q;
    logic             game_rst_n_q;
    logic             freeze_q;
    logic             match_over_q;
    logic [1:0]       countdown_q;
    logic [BCD_W-1:0] time_tens_q;
    logic [BCD_W-1:0] time_ones_q;
    logic [2:0]       round_num_q;
    logic [1:0]       p1_rounds_q;
    logic [1:0]       p2_rounds_q;
    winner_t          round_winner_q;
    winner_t          match_winner_q;
    logic [END_W-1:0] end_cnt_q;

    logic sync1_q, sync2_q, sync3_q, start_rise_q;
    logic tick;
    logic ko_p1_c, ko_p2_c, timeout_c, leave_c, match_done_c;
    winner_t health_winner_c;

    // Start button: two-flop synchroniser, then a registered rising-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            start_rise_q <= 1'b0;
        end else begin
            sync1_q      <= start_btn;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            start_rise_q <= sync2_q & ~sync3_q;
        end
    end

    // Leave conditions per phase; also restarts the prescaler on every transition.
    always_comb begin
        ko_p1_c         = (finish == WIN_P1);
        ko_p2_c         = (finish == WIN_P2);
        timeout_c       = tick && (time_tens_q == '0) && (time_ones_q == BCD_W'(1));
        health_winner_c = compare_winner(p1_health, p2_health);
        match_done_c    = (p1_rounds_q == 2'(ROUNDS_TO_WIN))
                       || (p2_rounds_q == 2'(ROUNDS_TO_WIN))
                       || (round_num_q == 3'(MAX_ROUNDS));
        leave_c = 1'b0;
        case (state_q)
            PH_IDLE, PH_MATCH_OVER: leave_c = start_rise_q;
            PH_COUNTDOWN:           leave_c = tick && (countdown_q == 2'd1);
            PH_FIGHT:               leave_c = ko_p1_c || ko_p2_c || timeout_c;
            PH_ROUND_END:           leave_c = tick && (end_cnt_q == END_LAST);
            default:                leave_c = 1'b0;
        endcase
    end

    sec_tick_gen #(
        .SEC_CYCLES(SEC_CYCLES)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(leave_c),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= PH_IDLE;
            game_rst_n_q   <= 1'b0;
            freeze_q       <= 1'b1;
            match_over_q   <= 1'b0;
            countdown_q    <= 2'd0;
            time_tens_q    <= '0;
            time_ones_q    <= '0;
            round_num_q    <= 3'd0;
            p1_rounds_q    <= 2'd0;
            p2_rounds_q    <= 2'd0;
            round_winner_q <= WIN_NONE;
            match_winner_q <= WIN_NONE;
            end_cnt_q      <= '0;
        end else begin
            case (state_q)
                PH_IDLE, PH_MATCH_OVER: begin
                    if (leave_c) begin
                        state_q        <= PH_COUNTDOWN;
                        game_rst_n_q   <= 1'b0;
                        freeze_q       <= 1'b1;
                        match_over_q   <= 1'b0;
                        p1_rounds_q    <= 2'd0;
                        p2_rounds_q    <= 2'd0;
                        round_winner_q <= WIN_NONE;
                        match_winner_q <= WIN_NONE;
                        round_num_q    <= 3'd1;
                        countdown_q    <= 2'd3;
                    end
                end
                PH_COUNTDOWN: begin
                    if (leave_c) begin
                        state_q        <= PH_FIGHT;
                        game_rst_n_q   <= 1'b1;
                        freeze_q       <= 1'b0;
                        countdown_q    <= 2'd0;
                        time_tens_q    <= RS_TENS;
                        time_ones_q    <= RS_ONES;
                        round_winner_q <= WIN_NONE;
                    end else if (tick) begin
                        countdown_q <= countdown_q - 2'd1;
                    end
                end
                PH_FIGHT: begin
                    // KO outranks the timer, even on the final tick.
                    if (ko_p1_c) begin
                        round_winner_q <= WIN_P1;
                        p1_rounds_q    <= tally_inc(p1_rounds_q);
                    end else if (ko_p2_c) begin
                        round_winner_q <= WIN_P2;
                        p2_rounds_q    <= tally_inc(p2_rounds_q);
                    end else if (timeout_c) begin
                        time_ones_q    <= '0;
                        round_winner_q <= health_winner_c;
                        if (health_winner_c == WIN_P1) begin
                            p1_rounds_q <= tally_inc(p1_rounds_q);
                        end else if (health_winner_c == WIN_P2) begin
                            p2_rounds_q <= tally_inc(p2_rounds_q);
                        end
                    end else if (tick) begin
                        if (time_ones_q == '0) begin
                            time_ones_q <= BCD_W'(9);
                            time_tens_q <= time_tens_q - BCD_W'(1);
                        end else begin
                            time_ones_q <= time_ones_q - BCD_W'(1);
                        end
                    end
                    if (leave_c) begin
                        state_q   <= PH_ROUND_END;
                        freeze_q  <= 1'b1;
                        end_cnt_q <= '0;
                    end
                end
                PH_ROUND_END: begin
                    if (leave_c) begin
                        if (match_done_c) begin
                            state_q        <= PH_MATCH_OVER;
                            match_over_q   <= 1'b1;
                            match_winner_q <= compare_winner(4'(p1_rounds_q), 4'(p2_rounds_q));
                        end else begin
                            state_q      <= PH_COUNTDOWN;
                            game_rst_n_q <= 1'b0;
                            round_num_q  <= round_num_q + 3'd1;
                            countdown_q  <= 2'd3;
                        end
                    end else if (tick) begin
                        end_cnt_q <= end_cnt_q + END_W'(1);
                    end
                end
                default: begin
                    state_q <= PH_IDLE;
                end
            endcase
        end
    end

    assign phase        = state_q;
    assign game_rst_n   = game_rst_n_q;
    assign freeze       = freeze_q;
    assign match_over   = match_over_q;
    assign countdown    = countdown_q;
    assign time_tens    = time_tens_q;
    assign time_ones    = time_ones_q;
    assign round_num    = round_num_q;
    assign p1_rounds    = p1_rounds_q;
    assign p2_rounds    = p2_rounds_q;
    assign round_winner = round_winner_q;
    assign match_winner = match_winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed vector bench for match_controller; instance b uses a 10-second round for the BCD walk.
module tb_match_controller;

    typedef struct packed {
        logic [2:0] phase;
        logic       rstn;
        logic       frz;
        logic [1:0] cd;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [2:0] rnd;
        logic [1:0] p1r;
        logic [1:0] p2r;
        logic [1:0] rw;
        logic       mo;
        logic [1:0] mw;
    } out_t;

    typedef struct {
        logic        start;
        logic [1:0]  fin;
        logic [3:0]  h1;
        logic [3:0]  h2;
        int unsigned wait_cyc;
        out_t        exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       start_btn;
    logic [1:0] finish;
    logic [3:0] p1_health;
    logic [3:0] p2_health;

    logic       a_rstn, a_frz, a_mo, b_rstn, b_frz, b_mo;
    logic [2:0] a_phase, a_rnd, b_phase, b_rnd;
    logic [1:0] a_cd, a_p1r, a_p2r, a_rw, a_mw, b_cd, b_p1r, b_p2r, b_rw, b_mw;
    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    out_t       out_a, out_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    vec_t        vq[$];

    match_controller #(
        .SEC_CYCLES(10), .ROUND_SECONDS(5), .END_SECONDS(2), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(5)
    ) dut_a (
        .clk(clk), .reset(reset), .start_btn(start_btn), .finish(finish),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_rst_n(a_rstn), .freeze(a_frz), .phase(a_phase), .countdown(a_cd),
        .time_tens(a_tens), .time_ones(a_ones), .round_num(a_rnd),
        .p1_rounds(a_p1r), .p2_rounds(a_p2r), .round_winner(a_rw),
        .match_over(a_mo), .match_winner(a_mw)
    );

    match_controller #(
        .SEC_CYCLES(10), .ROUND_SECONDS(10), .END_SECONDS(2), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(5)
    ) dut_b (
        .clk(clk), .reset(reset), .start_btn(start_btn), .finish(finish),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_rst_n(b_rstn), .freeze(b_frz), .phase(b_phase), .countdown(b_cd),
        .time_tens(b_tens), .time_ones(b_ones), .round_num(b_rnd),
        .p1_rounds(b_p1r), .p2_rounds(b_p2r), .round_winner(b_rw),
        .match_over(b_mo), .match_winner(b_mw)
    );

    assign out_a = {a_phase, a_rstn, a_frz, a_cd, a_tens, a_ones, a_rnd, a_p1r, a_p2r, a_rw, a_mo, a_mw};
    assign out_b = {b_phase, b_rstn, b_frz, b_cd, b_tens, b_ones, b_rnd, b_p1r, b_p2r, b_rw, b_mo, b_mw};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input int ph, input int rn, input int fz, input int cd,
                                input int tn, input int on, input int rd, input int a,
                                input int b, input int rw, input int mo, input int mw);
        out_t r;
        r.phase = 3'(ph); r.rstn = 1'(rn); r.frz = 1'(fz); r.cd = 2'(cd);
        r.tens = 4'(tn); r.ones = 4'(on); r.rnd = 3'(rd); r.p1r = 2'(a);
        r.p2r = 2'(b); r.rw = 2'(rw); r.mo = 1'(mo); r.mw = 2'(mw);
        return r;
    endfunction

    function automatic string fmt(input out_t v);
        return $sformatf("ph=%0d rstn=%0d frz=%0d cd=%0d t=%0d%0d rnd=%0d p1=%0d p2=%0d rw=%b mo=%0d mw=%b",
                         v.phase, v.rstn, v.frz, v.cd, v.tens, v.ones, v.rnd, v.p1r, v.p2r,
                         v.rw, v.mo, v.mw);
    endfunction

    task automatic check(input string name, input bit sel_b, input out_t exp);
        out_t act;
        act = sel_b ? out_b : out_a;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %s | want %s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic apply(input string name, input logic st, input logic [1:0] fn,
                         input logic [3:0] h1, input logic [3:0] h2, input int unsigned w,
                         input bit sel_b, input out_t exp);
        start_btn = st; finish = fn; p1_health = h1; p2_health = h2;
        repeat (w) @(posedge clk);
        @(negedge clk);
        check(name, sel_b, exp);
    endtask

    task automatic add(input logic st, input logic [1:0] fn, input int h1, input int h2,
                       input int unsigned w, input out_t exp);
        vec_t v;
        v.start = st; v.fin = fn; v.h1 = 4'(h1); v.h2 = 4'(h2); v.wait_cyc = w; v.exp = exp;
        vq.push_back(v);
    endtask

    initial begin
        out_t rst_v;
        rst_v = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Match 1: KO round, draw round, two P2 timeout rounds; start in FIGHT ignored.
        add(1, 0, 0, 0,  4, mk(1, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0,  9, mk(1, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0,  1, mk(1, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 10, mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0,  9, mk(1, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0,  1, mk(2, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        add(0, 0, 0, 0, 10, mk(2, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0));
        add(0, 1, 0, 0,  1, mk(3, 1, 1, 0, 0, 4, 1, 1, 0, 1, 0, 0));
        add(0, 0, 0, 0, 19, mk(3, 1, 1, 0, 0, 4, 1, 1, 0, 1, 0, 0));
        add(0, 0, 0, 0,  1, mk(1, 0, 1, 3, 0, 4, 2, 1, 0, 1, 0, 0));
        add(0, 0, 7, 7, 30, mk(2, 1, 0, 0, 0, 5, 2, 1, 0, 0, 0, 0));
        add(0, 0, 7, 7, 40, mk(2, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0));
        add(0, 0, 7, 7, 10, mk(3, 1, 1, 0, 0, 0, 2, 1, 0, 2, 0, 0));
        add(0, 0, 7, 7, 20, mk(1, 0, 1, 3, 0, 0, 3, 1, 0, 2, 0, 0));
        add(0, 0, 3, 9, 30, mk(2, 1, 0, 0, 0, 5, 3, 1, 0, 0, 0, 0));
        add(1, 0, 3, 9, 10, mk(2, 1, 0, 0, 0, 4, 3, 1, 0, 0, 0, 0));
        add(0, 0, 3, 9, 40, mk(3, 1, 1, 0, 0, 0, 3, 1, 1, 3, 0, 0));
        add(0, 0, 3, 9, 20, mk(1, 0, 1, 3, 0, 0, 4, 1, 1, 3, 0, 0));
        add(0, 0, 3, 9, 30, mk(2, 1, 0, 0, 0, 5, 4, 1, 1, 0, 0, 0));
        add(0, 0, 3, 9, 50, mk(3, 1, 1, 0, 0, 0, 4, 1, 2, 3, 0, 0));
        add(0, 0, 3, 9, 20, mk(4, 1, 1, 0, 0, 0, 4, 1, 2, 3, 1, 3));
        // Match 2: restart from MATCH_OVER, then five draws hit the round limit.
        add(1, 0, 7, 7,  4, mk(1, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        add(0, 0, 7, 7, 30, mk(2, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        add(0, 0, 7, 7, 50, mk(3, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 0));
        for (int r = 2; r <= 5; r++) begin
            add(0, 0, 7, 7, 50, mk(2, 1, 0, 0, 0, 5, r, 0, 0, 0, 0, 0));
            add(0, 0, 7, 7, 50, mk(3, 1, 1, 0, 0, 0, r, 0, 0, 2, 0, 0));
        end
        add(0, 0, 7, 7, 19, mk(3, 1, 1, 0, 0, 0, 5, 0, 0, 2, 0, 0));
        add(0, 0, 7, 7,  1, mk(4, 1, 1, 0, 0, 0, 5, 0, 0, 2, 1, 2));

        reset = 1'b1; start_btn = 1'b0; finish = 2'b00; p1_health = '0; p2_health = '0;
        repeat (3) @(negedge clk);
        check("reset_a", 1'b0, rst_v);
        check("reset_b", 1'b1, rst_v);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            apply($sformatf("vec%0d", i), vq[i].start, vq[i].fin, vq[i].h1, vq[i].h2,
                  vq[i].wait_cyc, 1'b0, vq[i].exp);
        end

        // KO on the same cycle as the final tick; health would otherwise favour P2.
        apply("ko_tick_cd",    1, 0, 2, 9,  4, 1'b0, mk(1, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        apply("ko_tick_fight", 0, 0, 2, 9, 30, 1'b0, mk(2, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        apply("ko_tick_pre",   0, 0, 2, 9, 49, 1'b0, mk(2, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        apply("ko_tick_ko",    0, 1, 2, 9,  1, 1'b0, mk(3, 1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0));
        apply("ko_tick_next",  0, 0, 2, 9, 20, 1'b0, mk(1, 0, 1, 3, 0, 1, 2, 1, 0, 1, 0, 0));
        apply("mid_fight",     0, 0, 2, 9, 33, 1'b0, mk(2, 1, 0, 0, 0, 5, 2, 1, 0, 0, 0, 0));

        // Asynchronous reset mid-FIGHT, checked before any further clock edge.
        #2 reset = 1'b1;
        #1;
        check("async_rst_a", 1'b0, rst_v);
        check("async_rst_b", 1'b1, rst_v);
        @(negedge clk);
        reset = 1'b0;
        apply("post_rst", 0, 0, 7, 7, 5, 1'b0, rst_v);

        // Ten-second round on instance b: BCD walk 10 -> 00 ending in a draw.
        apply("bcd_cd",    1, 0, 7, 7,  4, 1'b1, mk(1, 0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0));
        apply("bcd_start", 0, 0, 7, 7, 30, 1'b1, mk(2, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            if (k < 10) begin
                apply($sformatf("bcd_%0d", 10 - k), 0, 0, 7, 7, 10, 1'b1,
                      mk(2, 1, 0, 0, 0, 10 - k, 1, 0, 0, 0, 0, 0));
            end else begin
                apply("bcd_0", 0, 0, 7, 7, 10, 1'b1, mk(3, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/match_controller.md
# match_controller

Round and match sequencer for the street-fighter core. It drives the game core's active-low reset to start each round fresh. It runs a 3-2-1 countdown and a decimal round timer, and resolves each round from the core's `finish` code or, on timeout, from health. It tallies rounds to a best-of-N match result and exports phase, timer and score for the VGA overlay.

## Interface
- `SEC_CYCLES`, 100_000_000: clk cycles per one-second tick.
- `ROUND_SECONDS`, 99: round timer start value; legal range 1..99.
- `END_SECONDS`, 3: seconds the result is held in ROUND_END.
- `ROUNDS_TO_WIN`, 2: round wins that end the match.
- `MAX_ROUNDS`, 5: hard round limit, so draws cannot loop forever.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `start_btn` in 1: raw start button. Passed through a 2-flop synchroniser, then rising-edge detected.
- `finish` in 2: from the game core. 00 = running, 01 = P1 KO win, 11 = P2 KO win, 10 = treated as 00.
- `p1_health`, `p2_health` in 4: from the game core.
- `game_rst_n` out 1: active-low reset to the game core.
- `freeze` out 1: 1 in every phase except FIGHT.
- `phase` out 3: current state code.
- `countdown` out 2: 3..1 during COUNTDOWN, otherwise 0.
- `time_tens`, `time_ones` out 4 each: BCD round timer.
- `round_num` out 3: current round, 1-based.
- `p1_rounds`, `p2_rounds` out 2: round-win tallies.
- `round_winner` out 2: 00 none, 01 P1, 11 P2, 10 draw.
- `match_over` out 1: 1 while in MATCH_OVER.
- `match_winner` out 2: same encoding as `round_winner`.

## Operation
States: IDLE=0, COUNTDOWN=1, FIGHT=2, ROUND_END=3, MATCH_OVER=4.

- **IDLE**
  - Outputs: `game_rst_n`=0, `freeze`=1.
  - On a start rising edge:
    - clear `p1_rounds`/`p2_rounds`, `round_winner`, `match_winner`;
    - set `round_num`=1, `countdown`=3;
    - go to COUNTDOWN.
- **COUNTDOWN**
  - Outputs: `game_rst_n`=0. The core's health and positions are held at their reset values.
  - Each tick decrements `countdown`.
  - A tick seen while `countdown`==1:
    - sets `countdown`=0;
    - loads the timer with `ROUND_SECONDS` in BCD;
    - clears `round_winner`;
    - goes to FIGHT.
- **FIGHT**
  - Outputs: `game_rst_n`=1, `freeze`=0.
  - Checks are made in this priority order, one per cycle:
    1. `finish`==01: P1 wins; `p1_rounds`+1.
    2. `finish`==11: P2 wins; `p2_rounds`+1.
    3. Tick with the timer at 01: the timer becomes 00 and the round is decided by health. The higher health wins and gets the tally increment. Equal health gives `round_winner`=10 and no increment.
    4. Any other tick: BCD decrement. If ones is 0, ones becomes 9 and tens decrements; otherwise ones decrements.
  - Cases 1–3 set `round_winner` and go to ROUND_END.
  - A KO on the same cycle as the final tick resolves as a KO.
- **ROUND_END**
  - Outputs: `game_rst_n`=1, so the core keeps its KO pose. `freeze`=1.
  - Counts `END_SECONDS` ticks.
  - On the last tick:
    - if either tally == `ROUNDS_TO_WIN`, or `round_num` == `MAX_ROUNDS`, go to MATCH_OVER;
    - otherwise `round_num`+1, `countdown`=3, go to COUNTDOWN.
- **MATCH_OVER**
  - Outputs: `game_rst_n`=1, `match_over`=1.
  - `match_winner` is the higher tally, or 10 if the tallies are equal. It is registered on entry.
  - A start rising edge behaves exactly as in IDLE and begins a new match.
- Start edges are ignored in COUNTDOWN, FIGHT and ROUND_END.
- Tallies saturate at 3. This is unreachable with legal parameters.

## Timing
- **Reset values:**
  - state IDLE;
  - `game_rst_n` 0, `freeze` 1;
  - `countdown` 0, timer 00, `round_num` 0;
  - tallies 0, `round_winner` 00, `match_winner` 00, `match_over` 0.
- **All outputs are registered.** `phase` changes on the clock edge after the triggering event.
- **Tick generation:**
  - The prescaler clears to 0 on every state transition.
  - The tick is a one-cycle pulse when the prescaler is at `SEC_CYCLES`-1.
  - The first tick after entering a state therefore arrives exactly `SEC_CYCLES` cycles after entry.
- **Countdown length:** COUNTDOWN lasts 3×`SEC_CYCLES`. This holds the core in reset far longer than its slowed positioning clock period, so positions are reloaded.
- **Start latency:**
  - start pin → synchroniser + edge detect: 3 cycles;
  - edge → state change: 1 further cycle.
- **`finish` handling:**
  - `finish` is sampled unsynchronised; it is a same-clock signal from the core.
  - A KO is acted on in the cycle `finish` becomes nonzero.
- **Reset mid-operation:** asynchronous return to the reset values in all states, including mid-round.

## Structure
- Package `sf_match_pkg` holds:
  - the phase encodings;
  - the winner codes (00/01/11/10), which match the core's `finish` encoding;
  - the BCD digit width.
- Sub-module `sec_tick_gen`:
  - parameter `SEC_CYCLES`;
  - synchronous `clear` input;
  - single-cycle `tick` output.
- Round-end resolution and the BCD decrement stay inline.

## Test plan
All scenarios use `SEC_CYCLES`=10, `ROUND_SECONDS`=5, `END_SECONDS`=2.

1. Reset, then start pulse → COUNTDOWN.
   - `countdown` reads 3, 2, 1 at 10-cycle spacing.
   - FIGHT is entered 30 cycles after COUNTDOWN entry, with timer 05 and `game_rst_n` rising in that cycle.
2. FIGHT with `finish`=01 →
   - next cycle: ROUND_END, `round_winner`=01, `p1_rounds`=1;
   - 20 cycles later: COUNTDOWN with `round_num`=2.
3. Timer reaches 00 with `p1_health`=7, `p2_health`=7 →
   - `round_winner`=10, tallies unchanged, timer shows 00.
   - Repeat with `ROUND_SECONDS`=10 and check the BCD sequence 10→09→…→00.
4. `p2_health` > `p1_health` at timeout in two consecutive rounds →
   - `p2_rounds`=2, MATCH_OVER, `match_winner`=11;
   - a start pulse then clears the tallies and re-enters COUNTDOWN.
5. Five consecutive draw rounds → MATCH_OVER after round 5 with `match_winner`=10.
6. Edge cases:
   - `reset` asserted mid-FIGHT → every output takes its reset value in the same cycle.
   - `finish`=01 on the same cycle as the final tick → a KO win is recorded.
   - A start pulse during FIGHT is ignored.
